// File: rtl/knn_mem_pkg.sv
// Shared definitions for the banked 1R1W memory: bank-select sizing helpers,
// read-latency bounds and the controller state encoding.
package knn_mem_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } knn_state_e;

  // Number of low address bits that pick the bank (0 for a single bank).
  function automatic int bank_sel_bits(input int nb);
    return (nb > 1) ? $clog2(nb) : 0;
  endfunction

  // Width of a bank-select signal; never narrower than one bit.
  function automatic int bank_sel_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  // Address width inside one bank after the bank bits are stripped.
  function automatic int bank_addr_w(input int aw, input int nb);
    int w;
    w = aw - bank_sel_bits(nb);
    return (w < 1) ? 1 : w;
  endfunction

  // Keeps an out-of-range latency parameter inside the supported window.
  function automatic int clamp_latency(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/knn_uram_bank.sv
// Single-bank byte-masked 1R1W memory with a registered read port
// (one cycle from re to rdata). Same-address read/write returns old data;
// write-first behaviour is built on top of this in the parent.
module knn_uram_bank
  import knn_mem_pkg::*;
#(
  parameter int DataWidth = 256,
  parameter int Depth     = 2048,
  parameter int AddrW     = 11
) (
  input  logic                   clk,
  input  logic                   re,
  input  logic [AddrW-1:0]       raddr,
  output logic [DataWidth-1:0]   rdata,
  input  logic [DataWidth/8-1:0] we,
  input  logic [AddrW-1:0]       waddr,
  input  logic [DataWidth-1:0]   wdata
);

  localparam int ByteW = DataWidth / 8;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  // Byte-lane writes and registered read; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ByteW; i++) begin
      if (we[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/knn_uram_banked_1r1w.sv
// Banked byte-masked 1R1W memory. Bank = low address bits. After reset an
// INIT sweep zeroes every word (all banks in parallel) while init_busy=1.
// Reads are fully pipelined with ReadLatency cycles from ce0 to q0;
// same-cycle write/read to one address is resolved write-first here.
module knn_uram_banked_1r1w
  import knn_mem_pkg::*;
#(
  parameter int DataWidth    = 256,
  parameter int AddressRange = 4096,
  parameter int AddressWidth = 12,
  parameter int NumBanks     = 2,
  parameter int ReadLatency  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  output logic [DataWidth-1:0]    q0,
  output logic                    q0_valid,
  input  logic [AddressWidth-1:0] address1,
  input  logic                    ce1,
  input  logic [DataWidth/8-1:0]  we1,
  input  logic [DataWidth-1:0]    d1,
  output logic                    init_busy
);

  localparam int ByteW     = DataWidth / 8;
  localparam int BankBits  = bank_sel_bits(NumBanks);
  localparam int SelW      = bank_sel_w(NumBanks);
  localparam int BankAw    = bank_addr_w(AddressWidth, NumBanks);
  localparam int BankDepth = AddressRange / NumBanks;
  localparam int RdLat     = clamp_latency(ReadLatency);

  // Overlay the masked bytes of a newer write onto an older word.
  function automatic logic [DataWidth-1:0] byte_merge(
    input logic [DataWidth-1:0] old_w,
    input logic [DataWidth-1:0] new_w,
    input logic [ByteW-1:0]     mask
  );
    logic [DataWidth-1:0] r;
    r = old_w;
    for (int i = 0; i < ByteW; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  knn_state_e              state_q, state_d;
  logic [AddressWidth-1:0] cnt_q, cnt_d;
  logic                    init_busy_q, init_busy_d;

  // Next-state logic for the clear sweep: INIT counts through one bank depth.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_busy_d = init_busy_q;
    case (state_q)
      ST_INIT: begin
        init_busy_d = 1'b1;
        if (cnt_q == AddressWidth'(BankDepth - 1)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          init_busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q + AddressWidth'(1);
        end
      end
      ST_IDLE: begin
        init_busy_d = 1'b0;
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = '0;
        init_busy_d = 1'b1;
      end
    endcase
  end

  // Controller registers; reset restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign init_busy = init_busy_q;

  // Port acceptance and address decode.
  logic              sweep_wr;
  logic              port_open;
  logic              rd_oor, wr_oor;
  logic              rd_acc, wr_acc, fwd_hit;
  logic [SelW-1:0]   rd_sel, wr_sel;
  logic [BankAw-1:0] rd_baddr, wr_baddr, sweep_baddr;

  assign sweep_wr    = (state_q == ST_INIT) && reset;
  assign port_open   = !init_busy_q && reset;
  assign rd_oor      = (32'(address0) >= 32'(AddressRange));
  assign wr_oor      = (32'(address1) >= 32'(AddressRange));
  assign rd_acc      = ce0 && port_open;
  assign wr_acc      = ce1 && port_open && !wr_oor;
  assign fwd_hit     = rd_acc && wr_acc && (address0 == address1);
  assign rd_sel      = SelW'(address0 & AddressWidth'(NumBanks - 1));
  assign wr_sel      = SelW'(address1 & AddressWidth'(NumBanks - 1));
  assign rd_baddr    = BankAw'(address0 >> BankBits);
  assign wr_baddr    = BankAw'(address1 >> BankBits);
  assign sweep_baddr = BankAw'(cnt_q);

  logic [DataWidth-1:0] bank_rdata [NumBanks];
  logic                 bank_re    [NumBanks];
  logic [ByteW-1:0]     bank_we    [NumBanks];
  logic [BankAw-1:0]    bank_waddr [NumBanks];
  logic [DataWidth-1:0] bank_wdata [NumBanks];

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    assign bank_re[b]    = rd_acc && !rd_oor && (rd_sel == SelW'(b));
    assign bank_we[b]    = sweep_wr ? '1 :
                           (wr_acc && (wr_sel == SelW'(b))) ? we1 : '0;
    assign bank_waddr[b] = sweep_wr ? sweep_baddr : wr_baddr;
    assign bank_wdata[b] = sweep_wr ? '0 : d1;

    knn_uram_bank #(
      .DataWidth (DataWidth),
      .Depth     (BankDepth),
      .AddrW     (BankAw)
    ) u_bank (
      .clk   (clk),
      .re    (bank_re[b]),
      .raddr (rd_baddr),
      .rdata (bank_rdata[b]),
      .we    (bank_we[b]),
      .waddr (bank_waddr[b]),
      .wdata (bank_wdata[b])
    );
  end

  // ---- stage p0: bank read in flight, forwarding info captured at issue ----
  logic                 vld_p0_q;
  logic                 zero_p0_q;
  logic                 fwd_hit_p0_q;
  logic [SelW-1:0]      sel_p0_q;
  logic [ByteW-1:0]     fwd_mask_p0_q;
  logic [DataWidth-1:0] fwd_data_p0_q;
  logic [DataWidth-1:0] data_p0;

  // Read-qualifier control for p0; zero flag makes q0 read 0 out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p0_q     <= 1'b0;
      zero_p0_q    <= 1'b1;
      fwd_hit_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= rd_acc;
      if (rd_acc) begin
        zero_p0_q    <= rd_oor;
        fwd_hit_p0_q <= fwd_hit;
      end
    end
  end

  // Issue-time capture of bank select and the colliding write's bytes.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      sel_p0_q      <= rd_sel;
      fwd_mask_p0_q <= we1;
      fwd_data_p0_q <= d1;
    end
  end

  // Write-first merge on the bank output; out-of-range reads yield zero.
  always_comb begin
    data_p0 = byte_merge(bank_rdata[sel_p0_q], fwd_data_p0_q,
                         fwd_hit_p0_q ? fwd_mask_p0_q : '0);
    if (zero_p0_q) data_p0 = '0;
  end

  // ---- stages p1..: remaining latency, last stage holds q0 ----
  if (RdLat == 1) begin : g_out_lat1
    assign q0       = data_p0;
    assign q0_valid = vld_p0_q;
  end else begin : g_out_pipe
    logic [DataWidth-1:0] dat_q [RdLat-1];
    logic [RdLat-2:0]     vld_q;

    // Valid shift register with data advancing only behind a valid.
    always_ff @(posedge clk) begin
      if (!reset) begin
        vld_q <= '0;
        for (int s = 0; s < RdLat - 1; s++) dat_q[s] <= '0;
      end else begin
        vld_q[0] <= vld_p0_q;
        if (vld_p0_q) dat_q[0] <= data_p0;
        for (int s = 1; s < RdLat - 1; s++) begin
          vld_q[s] <= vld_q[s-1];
          if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign q0       = dat_q[RdLat-2];
    assign q0_valid = vld_q[RdLat-2];
  end

endmodule
